// File: rtl/ram_1mb_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: widths, FSM states, requester ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_1mb_arbiter_pkg;

  localparam int RAM_ADDR_W = 20;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // One-hot request mask for a requester id, bit 0 = A, bit 1 = B.
  function automatic logic [1:0] id_mask(req_id_e id);
    return (id == REQ_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_1mb_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
// Latency: combinational pick; pointer updates on the clock edge when upd_i is high.
// Backpressure: excluded requests are ignored this cycle; nothing is queued.
module ram_1mb_arbiter_rr_arb2
  import ram_1mb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] excl_i,
  input  logic       upd_i,
  input  req_id_e    upd_id_i,
  output req_id_e    win_o,
  output logic       vld_o
);

  req_id_e    last_q;
  req_id_e    last_d;
  logic [1:0] elig;

  // Pick among eligible requests; the last-granted pointer breaks ties.
  always_comb begin
    elig   = req_i & ~excl_i;
    vld_o  = |elig;
    win_o  = REQ_A;
    last_d = upd_i ? upd_id_i : last_q;
    if (elig == 2'b11) begin
      win_o = (last_q == REQ_A) ? REQ_B : REQ_A;
    end else if (elig[1]) begin
      win_o = REQ_B;
    end
  end

  // Pointer starts at B so A wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_1mb_arbiter.sv
// Round-robin arbiter/sequencer letting requesters A and B share one single-port 1 MB RAM.
// Latency: req seen in IDLE -> ISSUE next cycle -> done pulse the cycle after; 2 cycles/txn when contended.
// Backpressure: requester holds req and its command until done; the loser simply waits.
module ram_1mb_arbiter
  import ram_1mb_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state_q;
  req_id_e           owner_q;
  logic              we_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              a_gnt_q, b_gnt_q;
  logic              a_done_q, b_done_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  req_id_e           arb_win;
  logic              arb_vld;
  logic [1:0]        arb_excl;
  logic              launch;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The owner finishing in RESP may still hold req; keep it out of the next pick.
  assign arb_excl = (state_q == S_RESP) ? id_mask(owner_q) : 2'b00;

  ram_1mb_arbiter_rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({b_req, a_req}),
    .excl_i   (arb_excl),
    .upd_i    (state_q == S_RESP),
    .upd_id_i (owner_q),
    .win_o    (arb_win),
    .vld_o    (arb_vld)
  );

  // Command of the current arbitration winner, and whether a new transaction starts now.
  always_comb begin
    sel_we    = (arb_win == REQ_B) ? b_we    : a_we;
    sel_addr  = (arb_win == REQ_B) ? b_addr  : a_addr;
    sel_wdata = (arb_win == REQ_B) ? b_wdata : a_wdata;
    launch    = arb_vld && ((state_q == S_IDLE) || (state_q == S_RESP));
  end

  // Sequencer FSM with registered grant/done/RAM-drive outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= REQ_A;
      we_q        <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      ram_we_q <= 1'b0;
      case (state_q)
        S_IDLE: ;
        S_ISSUE: begin
          state_q  <= S_RESP;
          a_done_q <= (owner_q == REQ_A);
          b_done_q <= (owner_q == REQ_B);
        end
        S_RESP: begin
          if (!we_q) begin
            if (owner_q == REQ_A) a_rdata_q <= ram_rdata;
            else                  b_rdata_q <= ram_rdata;
          end
          a_gnt_q <= 1'b0;
          b_gnt_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // A new transaction overrides the IDLE/RESP defaults above.
      if (launch) begin
        state_q     <= S_ISSUE;
        owner_q     <= arb_win;
        we_q        <= sel_we;
        ram_we_q    <= sel_we;
        ram_addr_q  <= sel_addr;
        ram_wdata_q <= sel_wdata;
        a_gnt_q     <= (arb_win == REQ_A);
        b_gnt_q     <= (arb_win == REQ_B);
      end
    end
  end

  // Read data comes straight from the RAM during the done cycle, then from the hold register.
  assign a_rdata   = (a_done_q && !we_q) ? ram_rdata : a_rdata_q;
  assign b_rdata   = (b_done_q && !we_q) ? ram_rdata : b_rdata_q;
  // Gate with rst_n so a write can never land while reset is asserted.
  assign ram_we    = ram_we_q & rst_n;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;

endmodule

// File: tb/tb_ram_1mb_arbiter.sv
// Bench for ram_1mb_arbiter with a behavioural 1 MB RAM and a reference memory/arbitration model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_1mb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [19:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_gnt, a_done;
  logic [7:0]  a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [19:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic        b_gnt, b_done;
  logic [7:0]  b_rdata;
  logic        ram_we;
  logic [19:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit b_gnt_seen = 1'b0;

  // Reference model: expected memory contents and the last-granted requester (0=A, 1=B).
  bit [7:0] ref_mem [bit [19:0]];
  bit       model_last = 1'b1;

  // Environment RAM: single port, write on edge, registered read.
  logic [7:0] mem [0:(1<<20)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (b_gnt) b_gnt_seen = 1'b1;

  ram_1mb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    a_req = 1'b0;
    b_req = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  // Run one transaction for a single requester; returns read data and the done cycle.
  task automatic txn(input bit who, input bit we, input logic [19:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output int done_cyc, output bit got);
    got = 1'b0;
    rd = '0;
    done_cyc = 0;
    if (!who) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    else      begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if ((!who && a_done) || (who && b_done)) begin
        got = 1'b1;
        rd = who ? b_rdata : a_rdata;
        done_cyc = cyc;
      end
    end
    if (!who) a_req = 1'b0;
    else      b_req = 1'b0;
    if (got) begin
      model_last = who;
      if (we) ref_mem[addr] = wd;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'h12345; a_wdata = 8'h5A;
    b_req = 1'b1; b_we = 1'b1; b_addr = 20'h00042; b_wdata = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({a_gnt, b_gnt, a_done, b_done, ram_we} !== 5'b0) begin
        errors++; $display("FAIL reset_ctrl cycle %0d: gnt/done/we=%b expected 00000", i, {a_gnt, b_gnt, a_done, b_done, ram_we});
      end
      checks++;
      if (ram_addr !== 20'h0 || ram_wdata !== 8'h0 || a_rdata !== 8'h0 || b_rdata !== 8'h0) begin
        errors++; $display("FAIL reset_data cycle %0d: addr=%h wdata=%h ardata=%h brdata=%h expected zeros", i, ram_addr, ram_wdata, a_rdata, b_rdata);
      end
      #3;
      checks++;
      if (ram_we !== 1'b0) begin
        errors++; $display("FAIL reset_we_mid cycle %0d: ram_we=%b expected 0", i, ram_we);
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_single_a;
    logic [7:0] rd;
    int dc, prev;
    bit got;
    do_reset();
    b_gnt_seen = 1'b0;
    prev = -1;
    for (int i = 1; i <= 23; i += 2) begin
      txn(1'b0, 1'b1, 20'(i), 8'(i - 1), rd, dc, got);
      checks++;
      if (!got) begin errors++; $display("FAIL single_wr_timeout addr %0d: no a_done expected done", i); end
      if (prev >= 0) begin
        checks++;
        if (dc - prev != 3) begin errors++; $display("FAIL single_wr_spacing addr %0d: %0d cycles expected 3", i, dc - prev); end
      end
      prev = dc;
    end
    for (int i = 1; i <= 23; i += 2) begin
      txn(1'b0, 1'b0, 20'(i), 8'h00, rd, dc, got);
      checks++;
      if (!got || rd !== 8'(i - 1)) begin
        errors++; $display("FAIL single_rd addr %0d: got=%0d rdata=%h expected %h", i, got, rd, 8'(i - 1));
      end
      checks++;
      if (dc - prev != 3) begin errors++; $display("FAIL single_rd_spacing addr %0d: %0d cycles expected 3", i, dc - prev); end
      prev = dc;
    end
    checks++;
    if (b_gnt_seen !== 1'b0) begin errors++; $display("FAIL single_b_gnt: b_gnt seen=%0d expected 0", b_gnt_seen); end
  endtask

  task automatic test_same_cycle;
    int first_who;
    bit ga, gb;
    logic [7:0] brd;
    do_reset();
    ga = 1'b0; gb = 1'b0; first_who = -1; brd = '0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'd5; a_wdata = 8'hAA;
    b_req = 1'b1; b_we = 1'b0; b_addr = 20'd5; b_wdata = 8'h00;
    ref_mem[20'd5] = 8'hAA;
    for (int i = 0; i < 12 && !(ga && gb); i++) begin
      tick();
      if (a_done && !ga) begin ga = 1'b1; a_req = 1'b0; if (first_who < 0) first_who = 0; end
      if (b_done && !gb) begin gb = 1'b1; b_req = 1'b0; brd = b_rdata; if (first_who < 0) first_who = 1; end
    end
    a_req = 1'b0; b_req = 1'b0;
    model_last = 1'b1;
    checks++;
    if (!ga || !gb) begin errors++; $display("FAIL same_cycle_timeout: a_done=%0d b_done=%0d expected both", ga, gb); end
    checks++;
    if (first_who != 0) begin errors++; $display("FAIL same_cycle_order: first owner=%0d expected 0 (A)", first_who); end
    checks++;
    if (brd !== ref_mem[20'd5]) begin errors++; $display("FAIL same_cycle_rdata: b_rdata=%h expected %h", brd, ref_mem[20'd5]); end
    tick();
  endtask

  task automatic test_contention;
    logic [7:0] rd;
    int dc, ndone, prev;
    bit got, exp_own, own;
    txn(1'b0, 1'b1, 20'd2, 8'($urandom), rd, dc, got);
    txn(1'b1, 1'b1, 20'd3, 8'($urandom), rd, dc, got);
    do_reset();
    exp_own = 1'b0;
    ndone = 0;
    prev = 0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 20'd2;
    b_req = 1'b1; b_we = 1'b0; b_addr = 20'd3;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (a_done || b_done) begin
        own = b_done;
        checks++;
        if ((a_done && b_done) || own != exp_own) begin
          errors++; $display("FAIL contend_order done#%0d: a_done=%0d b_done=%0d expected owner %0d", ndone, a_done, b_done, exp_own);
        end
        checks++;
        if ((own ? b_rdata : a_rdata) !== ref_mem[own ? 20'd3 : 20'd2]) begin
          errors++; $display("FAIL contend_rdata done#%0d: rdata=%h expected %h", ndone, own ? b_rdata : a_rdata, ref_mem[own ? 20'd3 : 20'd2]);
        end
        checks++;
        if ({a_gnt, b_gnt} !== (own ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL contend_gnt done#%0d: a_gnt/b_gnt=%b expected %b", ndone, {a_gnt, b_gnt}, own ? 2'b01 : 2'b10);
        end
        if (ndone > 0) begin
          checks++;
          if (cyc - prev != 2) begin errors++; $display("FAIL contend_spacing done#%0d: %0d cycles expected 2", ndone, cyc - prev); end
        end
        prev = cyc;
        exp_own = ~exp_own;
        ndone++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    model_last = ~exp_own;
    checks++;
    if (ndone != 12) begin errors++; $display("FAIL contend_count: %0d dones expected 12", ndone); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] rd;
    int dc;
    bit got, seen_gnt;
    do_reset();
    txn(1'b0, 1'b1, 20'd7, 8'h11, rd, dc, got);
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'd7; a_wdata = 8'h55;
    seen_gnt = 1'b0;
    for (int i = 0; i < 6 && !seen_gnt; i++) begin
      tick();
      if (a_gnt) seen_gnt = 1'b1;
    end
    checks++;
    if (!seen_gnt) begin errors++; $display("FAIL midrst_issue: a_gnt=%0d expected 1", a_gnt); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin errors++; $display("FAIL midrst_we_gate: ram_we=%b expected 0", ram_we); end
    tick();
    a_req = 1'b0;
    checks++;
    if (a_done !== 1'b0 || a_gnt !== 1'b0) begin errors++; $display("FAIL midrst_abort: a_done=%b a_gnt=%b expected 0 0", a_done, a_gnt); end
    tick();
    rst_n = 1'b1;
    model_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done cycle %0d: a_done=%b expected 0", i, a_done); end
    end
    txn(1'b1, 1'b0, 20'd7, 8'h00, rd, dc, got);
    checks++;
    if (!got || rd !== ref_mem[20'd7]) begin errors++; $display("FAIL midrst_readback: got=%0d rdata=%h expected %h", got, rd, ref_mem[20'd7]); end
  endtask

  task automatic test_range_ends;
    logic [7:0] rd;
    int dc;
    bit got;
    do_reset();
    txn(1'($urandom), 1'b1, 20'hFFFFF, 8'hFF, rd, dc, got);
    txn(1'($urandom), 1'b1, 20'h00000, 8'h01, rd, dc, got);
    txn(1'($urandom), 1'b0, 20'hFFFFF, 8'h00, rd, dc, got);
    checks++;
    if (!got || rd !== 8'hFF) begin errors++; $display("FAIL range_top: got=%0d rdata=%h expected ff", got, rd); end
    txn(1'($urandom), 1'b0, 20'h00000, 8'h00, rd, dc, got);
    checks++;
    if (!got || rd !== 8'h01) begin errors++; $display("FAIL range_bottom: got=%0d rdata=%h expected 01", got, rd); end
  endtask

  task automatic test_random_pairs;
    logic [19:0] pool [5];
    logic [7:0]  rd, exp_ra, exp_rb, awd, bwd;
    logic [19:0] aad, bad;
    logic [1:0]  en;
    bit          awe, bwe, first, id, ga, gb;
    int          dc, first_seen;
    bit          got;
    pool[0] = 20'h00000; pool[1] = 20'h00001; pool[2] = 20'h00002;
    pool[3] = 20'hFFFFF; pool[4] = 20'h80000;
    do_reset();
    for (int k = 0; k < 5; k++) txn(1'b0, 1'b1, pool[k], 8'($urandom), rd, dc, got);
    for (int it = 0; it < 30; it++) begin
      en  = 2'($urandom_range(1, 3));
      awe = 1'($urandom); aad = pool[$urandom_range(0, 4)]; awd = 8'($urandom);
      bwe = 1'($urandom); bad = pool[$urandom_range(0, 4)]; bwd = 8'($urandom);
      exp_ra = '0; exp_rb = '0;
      first = (en == 2'b11) ? ~model_last : (en == 2'b10);
      for (int k = 0; k < 2; k++) begin
        id = (k == 0) ? first : ~first;
        if (en[id]) begin
          if (!id) begin if (awe) ref_mem[aad] = awd; else exp_ra = ref_mem[aad]; end
          else     begin if (bwe) ref_mem[bad] = bwd; else exp_rb = ref_mem[bad]; end
          model_last = id;
        end
      end
      a_req = en[0]; a_we = awe; a_addr = aad; a_wdata = awd;
      b_req = en[1]; b_we = bwe; b_addr = bad; b_wdata = bwd;
      ga = 1'b0; gb = 1'b0; first_seen = -1;
      for (int i = 0; i < 16 && ((en[0] && !ga) || (en[1] && !gb)); i++) begin
        tick();
        if (a_done && b_done) begin errors++; $display("FAIL rand_dual_done it %0d: both done in one cycle", it); end
        if (a_done && a_req) begin
          ga = 1'b1; a_req = 1'b0;
          if (first_seen < 0) first_seen = 0;
          if (!awe) begin
            checks++;
            if (a_rdata !== exp_ra) begin errors++; $display("FAIL rand_a_rdata it %0d: rdata=%h expected %h", it, a_rdata, exp_ra); end
          end
        end
        if (b_done && b_req) begin
          gb = 1'b1; b_req = 1'b0;
          if (first_seen < 0) first_seen = 1;
          if (!bwe) begin
            checks++;
            if (b_rdata !== exp_rb) begin errors++; $display("FAIL rand_b_rdata it %0d: rdata=%h expected %h", it, b_rdata, exp_rb); end
          end
        end
      end
      a_req = 1'b0; b_req = 1'b0;
      checks++;
      if (ga != en[0] || gb != en[1]) begin errors++; $display("FAIL rand_done it %0d: done a/b=%0d%0d expected %0d%0d", it, ga, gb, en[0], en[1]); end
      checks++;
      if (first_seen != int'(first)) begin errors++; $display("FAIL rand_order it %0d: first owner=%0d expected %0d", it, first_seen, first); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_same_cycle();
    test_contention();
    test_reset_mid_write();
    test_range_ends();
    test_random_pairs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
